// File: rtl/mealy_sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first for a programmed number of
// repetitions with an idle gap between them, flagging the last bit of every repetition.
module mealy_sequence_generator #(
   parameter int PATTERN_W = 4,
   parameter int LEN_W     = 3,
   parameter int REP_W     = 8,
   parameter int GAP_W     = 4
) (
   input  logic                 i_Clk,
   input  logic                 Reset_n,
   input  logic                 i_Start,
   input  logic [PATTERN_W-1:0] i_Pattern,
   input  logic [LEN_W-1:0]     i_Len,
   input  logic [REP_W-1:0]     i_Repeat,
   input  logic [GAP_W-1:0]     i_Gap,
   input  logic                 i_Idle_Level,
   output logic                 Sequence,
   output logic                 o_Valid,
   output logic                 o_Last,
   output logic                 o_Busy,
   output logic                 o_Done,
   output logic [1:0]           o_State
);

   localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_e;

   // Handshake: i_Start is a level sampled on any rising edge while IDLE; there is no ready signal,
   // o_Busy high means a start would be ignored, and o_Done marks the single cycle before IDLE.

   state_e               state_q, state_d;
   logic [PATTERN_W-1:0] pattern_q, pattern_d;
   logic [IDX_W-1:0]     top_q, top_d;
   logic [IDX_W-1:0]     bit_q, bit_d;
   logic [REP_W-1:0]     rep_q, rep_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 idle_q, idle_d;
   logic                 seq_q, seq_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [LEN_W-1:0]     eff_len;
   logic [LEN_W-1:0]     len_m1;
   logic [IDX_W-1:0]     bit_dec;

   assign eff_len = (i_Len > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : i_Len;
   assign len_m1  = eff_len - LEN_W'(1);
   assign bit_dec = bit_q - IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      top_d     = top_q;
      bit_d     = bit_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      idle_d    = idle_q;
      seq_d     = idle_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      busy_d    = 1'b1;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (i_Start) begin
               pattern_d = i_Pattern;
               top_d     = len_m1[IDX_W-1:0];
               rep_d     = i_Repeat;
               gap_d     = i_Gap;
               idle_d    = i_Idle_Level;
               busy_d    = 1'b1;
               seq_d     = i_Idle_Level;
               if (eff_len == '0 || i_Repeat == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  // rep_q counts repetitions still to start after the current one
                  state_d = ST_SEND;
                  bit_d   = len_m1[IDX_W-1:0];
                  seq_d   = i_Pattern[len_m1[IDX_W-1:0]];
                  valid_d = 1'b1;
                  last_d  = (len_m1 == '0);
                  rep_d   = i_Repeat - REP_W'(1);
               end
            end
         end
         ST_SEND: begin
            if (bit_q != '0) begin
               bit_d   = bit_dec;
               seq_d   = pattern_q[bit_dec];
               valid_d = 1'b1;
               last_d  = (bit_dec == '0);
            end else if (rep_q == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               rep_d = rep_q - REP_W'(1);
               if (gap_q != '0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap_q - GAP_W'(1);
               end else begin
                  bit_d   = top_q;
                  seq_d   = pattern_q[top_q];
                  valid_d = 1'b1;
                  last_d  = (top_q == '0);
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_SEND;
               bit_d   = top_q;
               seq_d   = pattern_q[top_q];
               valid_d = 1'b1;
               last_d  = (top_q == '0);
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         top_q     <= '0;
         bit_q     <= '0;
         rep_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         idle_q    <= 1'b0;
         seq_q     <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         top_q     <= top_d;
         bit_q     <= bit_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         idle_q    <= idle_d;
         seq_q     <= seq_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign Sequence = seq_q;
   assign o_Valid  = valid_q;
   assign o_Last   = last_q;
   assign o_Busy   = busy_q;
   assign o_Done   = done_q;
   assign o_State  = state_q;

endmodule

// File: tb/tb_mealy_sequence_generator.sv
// Bench for mealy_sequence_generator: a per-cycle expectation queue built from the pattern/repeat/gap
// rules is compared against the outputs every cycle, plus literal checks of captured waveforms.
module tb_mealy_sequence_generator;

   logic       i_Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       i_Start = 1'b0;
   logic [3:0] i_Pattern = '0;
   logic [2:0] i_Len = '0;
   logic [7:0] i_Repeat = '0;
   logic [3:0] i_Gap = '0;
   logic       i_Idle_Level = 1'b0;
   logic       Sequence, o_Valid, o_Last, o_Busy, o_Done;
   logic [1:0] o_State;

   int n_cmp = 0;
   int n_fail = 0;

   // expected per-cycle tuple: {seq, valid, last, busy, done}
   logic [4:0] exp_q[$];
   logic [4:0] cur_exp = '0;
   logic       idle_m = 1'b0;
   logic       chk_en = 1'b0;

   logic cap_seq   [0:299];
   logic cap_valid [0:299];
   logic cap_last  [0:299];
   logic cap_done  [0:299];
   int   done_cycle, last_count, valid_count, done_count;
   logic [31:0] vec;

   mealy_sequence_generator dut (
      .i_Clk(i_Clk), .Reset_n(Reset_n), .i_Start(i_Start), .i_Pattern(i_Pattern),
      .i_Len(i_Len), .i_Repeat(i_Repeat), .i_Gap(i_Gap), .i_Idle_Level(i_Idle_Level),
      .Sequence(Sequence), .o_Valid(o_Valid), .o_Last(o_Last), .o_Busy(o_Busy),
      .o_Done(o_Done), .o_State(o_State)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lay out the whole transfer cycle by cycle: bits MSB first, gaps between repetitions, then DONE.
   function automatic void build(input logic [3:0] pat, input int len, input int rep,
                                 input int gap, input logic idle);
      int l;
      l = (len > 4) ? 4 : len;
      if (l == 0 || rep == 0) begin
         exp_q.push_back({idle, 4'b0011});
      end else begin
         for (int r = 0; r < rep; r++) begin
            for (int b = l - 1; b >= 0; b--)
               exp_q.push_back({pat[b], 1'b1, (b == 0), 2'b10});
            if (r < rep - 1)
               for (int g = 0; g < gap; g++) exp_q.push_back({idle, 4'b0010});
         end
         exp_q.push_back({idle, 4'b0011});
      end
   endfunction

   always @(posedge i_Clk) begin
      if (!Reset_n) begin
         exp_q.delete();
         cur_exp <= '0;
         idle_m  <= 1'b0;
      end else if (exp_q.size() > 0) begin
         cur_exp <= exp_q.pop_front();
      end else if (!cur_exp[1] && i_Start) begin
         idle_m <= i_Idle_Level;
         build(i_Pattern, int'(i_Len), int'(i_Repeat), int'(i_Gap), i_Idle_Level);
         cur_exp <= exp_q.pop_front();
      end else begin
         cur_exp <= {idle_m, 4'b0000};
      end
   end

   always @(negedge i_Clk)
      if (chk_en)
         check("cycle_outputs", {27'b0, Sequence, o_Valid, o_Last, o_Busy, o_Done}, {27'b0, cur_exp});

   task automatic start_op(input logic [3:0] pat, input logic [2:0] len, input logic [7:0] rep,
                           input logic [3:0] gap, input logic idle);
      @(negedge i_Clk);
      i_Pattern = pat; i_Len = len; i_Repeat = rep; i_Gap = gap; i_Idle_Level = idle;
      i_Start = 1'b1;
      @(posedge i_Clk);
      #1;
      i_Start      = 1'b0;
      i_Pattern    = 4'($urandom_range(0, 15));
      i_Len        = 3'($urandom_range(0, 7));
      i_Repeat     = 8'($urandom_range(0, 255));
      i_Gap        = 4'($urandom_range(0, 15));
      i_Idle_Level = 1'($urandom_range(0, 1));
   endtask

   // Record cycles 1..n after the start edge; optionally hold i_Start high for cycles s0..s1-1.
   task automatic capture(input int n, input int s0, input int s1);
      done_cycle = 0; last_count = 0; valid_count = 0; done_count = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge i_Clk);
         cap_seq[c] = Sequence; cap_valid[c] = o_Valid; cap_last[c] = o_Last; cap_done[c] = o_Done;
         if (o_Done) begin
            done_count++;
            if (done_cycle == 0) done_cycle = c;
         end
         if (o_Last) last_count++;
         if (o_Valid) valid_count++;
         i_Start = (c >= s0 && c < s1) ? 1'b1 : 1'b0;
      end
      i_Start = 1'b0;
   endtask

   function automatic logic [31:0] seq_vec(input int n);
      logic [31:0] v = '0;
      for (int c = 1; c <= n; c++) v = {v[30:0], cap_seq[c]};
      return v;
   endfunction

   function automatic logic [31:0] last_vec(input int n);
      logic [31:0] v = '0;
      for (int c = 1; c <= n; c++) v = {v[30:0], cap_last[c]};
      return v;
   endfunction

   function automatic logic [31:0] valid_vec(input int n);
      logic [31:0] v = '0;
      for (int c = 1; c <= n; c++) v = {v[30:0], cap_valid[c]};
      return v;
   endfunction

   initial begin
      // reset with random inputs, including start strobes
      for (int i = 0; i < 3; i++) begin
         @(negedge i_Clk);
         i_Start      = 1'($urandom_range(0, 1));
         i_Pattern    = 4'($urandom_range(0, 15));
         i_Len        = 3'($urandom_range(0, 7));
         i_Repeat     = 8'($urandom_range(0, 255));
         i_Gap        = 4'($urandom_range(0, 15));
         i_Idle_Level = 1'($urandom_range(0, 1));
         chk_en       = 1'b1;
      end
      check("reset_outputs", {27'b0, Sequence, o_Valid, o_Last, o_Busy, o_Done}, 32'd0);
      @(negedge i_Clk);
      i_Start = 1'b0;
      Reset_n = 1'b1;
      capture(3, 0, 0);
      check("reset_no_done", done_count, 0);

      // single repetition
      start_op(4'b1011, 3'd4, 8'd1, 4'd0, 1'b0);
      capture(7, 0, 0);
      check("single_seq", seq_vec(4), 32'b1011);
      check("single_last", last_vec(4), 32'b0001);
      check("single_done_cycle", done_cycle, 5);

      // back-to-back repetitions
      start_op(4'b0111, 3'd3, 8'd3, 4'd0, 1'b0);
      capture(11, 0, 0);
      check("b2b_seq", seq_vec(9), 32'h1FF);
      check("b2b_last", last_vec(9), 32'b001001001);
      check("b2b_done_cycle", done_cycle, 10);

      // gap between repetitions, idle level high
      start_op(4'b1100, 3'd4, 8'd2, 4'd2, 1'b1);
      capture(12, 0, 0);
      check("gap_seq", seq_vec(10), 32'b1100111100);
      check("gap_valid", valid_vec(10), 32'b1111001111);
      check("gap_done_cycle", done_cycle, 11);
      check("gap_idle_after", {31'b0, cap_seq[12]}, 32'd1);

      // length zero and repeat zero go straight to DONE
      start_op(4'hF, 3'd0, 8'd3, 4'd2, 1'b1);
      capture(3, 0, 0);
      check("len0_done_cycle", done_cycle, 1);
      check("len0_no_valid", valid_count, 0);
      start_op(4'hF, 3'd4, 8'd0, 4'd2, 1'b0);
      capture(3, 0, 0);
      check("rep0_done_cycle", done_cycle, 1);
      check("rep0_no_valid", valid_count, 0);

      // length clamped to the pattern width
      start_op(4'b1010, 3'd7, 8'd1, 4'd0, 1'b0);
      capture(6, 0, 0);
      check("clamp_seq", seq_vec(4), 32'b1010);
      check("clamp_done_cycle", done_cycle, 5);

      // start held high while busy, including through DONE, is ignored
      start_op(4'b1001, 3'd4, 8'd2, 4'd3, 1'b0);
      capture(14, 3, 13);
      check("busy_done_cycle", done_cycle, 12);
      check("busy_last_count", last_count, 2);
      check("busy_done_count", done_count, 1);

      // maximum repeat count
      start_op(4'b0001, 3'd1, 8'd255, 4'd0, 1'b0);
      capture(258, 0, 0);
      check("maxrep_last_count", last_count, 255);
      check("maxrep_done_cycle", done_cycle, 256);

      // reset during the second repetition
      start_op(4'b0101, 3'd3, 8'd5, 4'd1, 1'b1);
      repeat (5) @(negedge i_Clk);
      Reset_n = 1'b0;
      repeat (2) @(negedge i_Clk);
      Reset_n = 1'b1;
      capture(10, 0, 0);
      check("midrst_no_done", done_count, 0);
      check("midrst_no_valid", valid_count, 0);
      check("midrst_seq_low", {31'b0, cap_seq[10]}, 32'd0);
      start_op(4'b1011, 3'd4, 8'd1, 4'd0, 1'b0);
      capture(6, 0, 0);
      check("post_rst_seq", seq_vec(4), 32'b1011);
      check("post_rst_done_cycle", done_cycle, 5);

      @(negedge i_Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
